// File: rtl/turnsignal_decoder.sv
// turnsignal_decoder: recovers off/right/left/hazard from the l1/r1 blink
// pattern. Define TURNSIG_DECODER_FAULT_EN for the sticky flip-fault flag.
module turnsignal_decoder #(
  parameter int TIMEOUT = 16,
  parameter int CONFIRM = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       l1,
  input  logic       r1,
  output logic [1:0] mode,
  output logic       valid,
  output logic       changed,
  output logic [7:0] pulse_cnt,
  output logic       fault
);

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    CONF8  = 8'(CONFIRM);
  localparam bit            FAST   = (CONFIRM == 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_CAND = 2'd1,
    S_LOCK = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [1:0]    cand_q, cand_d;
  logic          valid_q, valid_d;
  logic          changed_q, changed_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    match_q, match_d;
  logic [TW-1:0] timer_q, timer_d;

  logic       pulse;
  logic [1:0] pat;
  logic       expire;
  logic       confirm;
  logic       flip;
  logic       lock_ev;
  logic       drop_ev;

  assign pulse   = l1 | r1;
  assign pat     = {l1, r1};
  assign expire  = !pulse && (timer_q == T_LAST);
  assign confirm = (pat == cand_q) && (match_q == CONF8 - 8'd1);
  assign flip    = pulse && (pat != mode_q);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_OFF;
      mode_q    <= 2'b00;
      cand_q    <= 2'b00;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      cnt_q     <= 8'd0;
      match_q   <= 8'd0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cand_q    <= cand_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF: begin
        if (pulse) state_d = FAST ? S_LOCK : S_CAND;
      end
      S_CAND: begin
        if (pulse) begin
          if (confirm) state_d = S_LOCK;
        end else if (expire) begin
          state_d = S_OFF;
        end
      end
      S_LOCK: begin
        if (flip) state_d = FAST ? S_LOCK : S_CAND;
        else if (expire) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  // Candidate tracking, idle timer and reported mode
  always_comb begin
    mode_d    = mode_q;
    cand_d    = cand_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    cnt_d     = cnt_q;
    match_d   = match_q;
    timer_d   = timer_q;
    lock_ev   = 1'b0;
    drop_ev   = 1'b0;
    unique case (state_q)
      S_OFF: begin
        if (pulse) begin
          timer_d = '0;
          cand_d  = pat;
          match_d = 8'd1;
          lock_ev = FAST;
        end
      end
      S_CAND, S_LOCK: begin
        if (pulse) begin
          timer_d = '0;
          if (state_q == S_LOCK && !flip) begin
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          end else if (state_q == S_CAND && pat == cand_q) begin
            match_d = match_q + 8'd1;
            lock_ev = confirm;
          end else begin
            cand_d  = pat;
            match_d = 8'd1;
            lock_ev = FAST;
          end
        end else if (expire) begin
          drop_ev = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (lock_ev) begin
      mode_d    = pat;
      valid_d   = 1'b1;
      cnt_d     = CONF8;
      changed_d = 1'b1;
      match_d   = 8'd0;
    end
    if (drop_ev) begin
      timer_d = '0;
      match_d = 8'd0;
      cand_d  = 2'b00;
      if (valid_q) begin
        mode_d    = 2'b00;
        valid_d   = 1'b0;
        cnt_d     = 8'd0;
        changed_d = 1'b1;
      end
    end
  end

  assign mode      = mode_q;
  assign valid     = valid_q;
  assign changed   = changed_q;
  assign pulse_cnt = cnt_q;

`ifdef TURNSIG_DECODER_FAULT_EN
  logic fault_q, fault_d;

  // Sticky flag for a direction change with no idle gap
  always_comb begin
    fault_d = fault_q;
    if (state_q == S_LOCK && flip) fault_d = 1'b1;
    if (drop_ev) fault_d = 1'b0;
  end

  // Fault register
  always_ff @(posedge clk) begin
    if (!rst) fault_q <= 1'b0;
    else      fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_turnsignal_decoder.sv
// tb_turnsignal_decoder: directed stimulus, run-length reference model
// compared every cycle, plus literal spot checks.
module tb_turnsignal_decoder;

  localparam int TIMEOUT = 16;
  localparam int CONFIRM = 2;
`ifdef TURNSIG_DECODER_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       l1  = 1'b0;
  logic       r1  = 1'b0;
  logic [1:0] mode;
  logic       valid;
  logic       changed;
  logic [7:0] pulse_cnt;
  logic       fault;

  turnsignal_decoder #(
    .TIMEOUT(TIMEOUT),
    .CONFIRM(CONFIRM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .l1       (l1),
    .r1       (r1),
    .mode     (mode),
    .valid    (valid),
    .changed  (changed),
    .pulse_cnt(pulse_cnt),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a mode locks once CONFIRM identical pulses have been
  // seen in a row; TIMEOUT idle cycles with activity pending end it all.
  logic [1:0] m_mode = 2'b00;
  logic       m_valid = 1'b0;
  logic       m_changed = 1'b0;
  logic       m_fault = 1'b0;
  int         m_cnt = 0;
  logic [1:0] run_pat = 2'b00;
  int         run_len = 0;
  int         idle = 0;

  always @(posedge clk) begin
    m_changed = 1'b0;
    if (!rst) begin
      m_mode = 2'b00; m_valid = 1'b0; m_fault = 1'b0;
      m_cnt = 0; run_pat = 2'b00; run_len = 0; idle = 0;
    end else if (l1 | r1) begin
      idle = 0;
      if (m_valid && {l1, r1} != m_mode) m_fault = m_fault | FEN;
      if (run_len > 0 && {l1, r1} == run_pat) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_pat = {l1, r1};
        run_len = 1;
      end
      if (run_len == CONFIRM) begin
        m_mode = run_pat; m_valid = 1'b1;
        m_cnt = CONFIRM; m_changed = 1'b1;
      end else if (run_len > CONFIRM && m_valid && run_pat == m_mode
                   && m_cnt < 255) begin
        m_cnt++;
      end
    end else if (run_len > 0) begin
      idle++;
      if (idle == TIMEOUT) begin
        run_len = 0; idle = 0; m_fault = 1'b0;
        if (m_valid) begin
          m_mode = 2'b00; m_valid = 1'b0;
          m_cnt = 0; m_changed = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking)
      chk("cycle", {3'b0, mode, valid, changed, pulse_cnt, fault},
          {3'b0, m_mode, m_valid, m_changed, 8'(m_cnt), m_fault});
  end

  task automatic step(input logic l, input logic r);
    l1 = l;
    r1 = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    step(1'b1, 1'b1);
    checking = 1'b1;
    step(1'b1, 1'b1);
    chk("rst_mode", 16'(mode), 16'h0);
    chk("rst_valid", 16'(valid), 16'h0);
    chk("rst_changed", 16'(changed), 16'h0);
    chk("rst_cnt", 16'(pulse_cnt), 16'h0);
    chk("rst_fault", 16'(fault), 16'h0);
    rst = 1'b1;

    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("left_mode", 16'(mode), 16'h2);
    chk("left_valid", 16'(valid), 16'h1);
    chk("left_changed", 16'(changed), 16'h1);
    chk("left_cnt", 16'(pulse_cnt), 16'h2);
    step(1'b0, 1'b0);
    chk("left_chg_once", 16'(changed), 16'h0);
    step(1'b1, 1'b0);
    chk("left_cnt3", 16'(pulse_cnt), 16'h3);

    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("flip_hold", 16'(mode), 16'h2);
    chk("flip_fault", 16'(fault), 16'(FEN));
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("flip_mode", 16'(mode), 16'h1);
    chk("flip_changed", 16'(changed), 16'h1);
    chk("flip_cnt", 16'(pulse_cnt), 16'h2);

    idles(15);
    chk("to15_valid", 16'(valid), 16'h1);
    step(1'b0, 1'b0);
    chk("to16_mode", 16'(mode), 16'h0);
    chk("to16_valid", 16'(valid), 16'h0);
    chk("to16_changed", 16'(changed), 16'h1);
    chk("to16_fault", 16'(fault), 16'h0);

    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("haz_mode", 16'(mode), 16'h3);
    idles(15);
    step(1'b1, 1'b1);
    chk("haz_keep", 16'(mode), 16'h3);
    chk("haz_cnt", 16'(pulse_cnt), 16'h3);
    idles(15);
    chk("haz_15", 16'(valid), 16'h1);
    step(1'b0, 1'b0);
    chk("haz_drop", 16'({valid, changed}), 16'h1);

    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("mm_nolock", 16'(valid), 16'h0);
    step(1'b0, 1'b1);
    chk("mm_lock", 16'({mode, valid, changed}), 16'h7);
    idles(16);

    step(1'b1, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0);
    chk("rmc_valid", 16'(valid), 16'h0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("rmc_lock", 16'({mode, valid}), 16'h5);

    for (int i = 0; i < 260; i++) step(1'b1, 1'b0);
    chk("sat_cnt", 16'(pulse_cnt), 16'hFF);

    rst = 1'b0;
    step(1'b1, 1'b1);
    chk("rst_lock", 16'({mode, valid, pulse_cnt}), 16'h0);
    rst = 1'b1;
    step(1'b0, 1'b0);
    @(negedge clk);
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
